// File: rtl/x_stack_mpu_if.sv
// Core-side bus seen by the stack memory-protection monitor.
//   pc, data_addr, data_en, data_wr, irq : core activity for the current cycle
//   reset                                : reset request back to the core
//   viol_code, viol_region, viol_cnt     : violation log
// master = core/bench side, slave = monitor side.
interface x_stack_mpu_if;
    logic [15:0] pc;
    logic [15:0] data_addr;
    logic        data_en;
    logic        data_wr;
    logic        irq;
    logic        reset;
    logic [2:0]  viol_code;
    logic [2:0]  viol_region;
    logic [7:0]  viol_cnt;

    modport master (
        output pc, data_addr, data_en, data_wr, irq,
        input  reset, viol_code, viol_region, viol_cnt
    );

    modport slave (
        input  pc, data_addr, data_en, data_wr, irq,
        output reset, viol_code, viol_region, viol_cnt
    );
endinterface

// File: rtl/x_stack_mpu.sv
// Execution-aware memory-protection monitor for the openMSP430 attestation path.
// Checks pc, data bus and irq every cycle against NREG policy regions and a trusted
// code block (TCB); any violation pulls the core into reset in the same cycle and keeps
// it there until the kill time has elapsed and the core sits at the reset handler.
// Ports:
//   i_mclk     system clock
//   i_reset_n  asynchronous active-low reset
//   io_bus     x_stack_mpu_if.slave: pc/data_addr/data_en/data_wr/irq in,
//              reset/viol_code/viol_region/viol_cnt out
module x_stack_mpu #(
    parameter int unsigned        NREG          = 4,
    parameter logic [NREG*16-1:0] REG_BASE      = {16'h0270, 16'h0230, 16'h6A00, 16'h0400},
    parameter logic [NREG*16-1:0] REG_SIZE      = {16'h0002, 16'h0020, 16'h0040, 16'h0100},
    parameter logic [NREG*3-1:0]  REG_POLICY    = {3'b110, 3'b100, 3'b001, 3'b101},
    parameter logic [15:0]        TCB_BASE      = 16'hA000,
    parameter logic [15:0]        TCB_SIZE      = 16'h1000,
    parameter logic [15:0]        RESET_HANDLER = 16'h0000,
    parameter int unsigned        KILL_MIN      = 4
) (
    input  logic          i_mclk,
    input  logic          i_reset_n,
    x_stack_mpu_if.slave  io_bus
);
    localparam logic [16:0] TCB_LAST = {1'b0, TCB_BASE} + {1'b0, TCB_SIZE} - 17'd2;
    localparam logic [7:0]  KILL_MAX = 8'(KILL_MIN);

    typedef enum logic {StRun, StKill} state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_kill_cnt, w_kill_cnt_next;
    logic        r_prev_in_tcb;
    logic [15:0] r_prev_pc;
    logic [2:0]  r_viol_code, r_viol_region;
    logic [7:0]  r_viol_cnt;

    logic            w_in_tcb, w_access;
    logic [NREG-1:0] w_in_reg, w_c1, w_c2, w_wr_tgt;
    logic            w_c3, w_c4, w_c5, w_c6;
    logic [2:0]      w_code, w_region;
    logic            w_viol, w_exit, w_reset_req;

    assign w_in_tcb = ({1'b0, io_bus.pc} >= {1'b0, TCB_BASE}) && ({1'b0, io_bus.pc} <= TCB_LAST);
    assign w_access = io_bus.data_en | io_bus.data_wr;

    // 17-bit bounds so a region ending at 16'hFFFF cannot wrap.
    for (genvar g = 0; g < NREG; g++) begin : g_reg
        localparam logic [16:0] BASE = {1'b0, REG_BASE[g*16 +: 16]};
        localparam logic [16:0] SIZE = {1'b0, REG_SIZE[g*16 +: 16]};
        assign w_in_reg[g] = (SIZE != 17'd0) && ({1'b0, io_bus.data_addr} >= BASE)
                             && ({1'b0, io_bus.data_addr} <= BASE + SIZE - 17'd1);
        assign w_c1[g]     = !w_in_tcb && w_access && w_in_reg[g] && REG_POLICY[g*3];
        assign w_c2[g]     = !w_in_tcb && io_bus.data_wr && w_in_reg[g] && REG_POLICY[g*3+1];
        assign w_wr_tgt[g] = w_in_reg[g] && REG_POLICY[g*3+2];
    end

    assign w_c3 = w_in_tcb && io_bus.data_wr && !(|w_wr_tgt);
    assign w_c4 = w_in_tcb && !r_prev_in_tcb && (io_bus.pc != TCB_BASE);
    assign w_c5 = !w_in_tcb && r_prev_in_tcb && (r_prev_pc != TCB_LAST[15:0]);
    assign w_c6 = io_bus.irq && w_in_tcb;

    function automatic logic [2:0] f_lowest(input logic [NREG-1:0] v);
        f_lowest = 3'd0;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if (v[i]) f_lowest = 3'(i);
        end
    endfunction

    // Lowest cause code wins; only causes 1 and 2 carry a region index.
    always_comb begin
        w_code   = 3'd0;
        w_region = 3'd0;
        if (|w_c1) begin
            w_code   = 3'd1;
            w_region = f_lowest(w_c1);
        end else if (|w_c2) begin
            w_code   = 3'd2;
            w_region = f_lowest(w_c2);
        end else if (w_c3) begin
            w_code = 3'd3;
        end else if (w_c4) begin
            w_code = 3'd4;
        end else if (w_c5) begin
            w_code = 3'd5;
        end else if (w_c6) begin
            w_code = 3'd6;
        end
    end

    assign w_viol = (w_code != 3'd0);

    always_comb begin
        w_state_next    = r_state;
        w_kill_cnt_next = r_kill_cnt;
        w_exit          = 1'b0;
        w_reset_req     = 1'b0;
        unique case (r_state)
            StRun: begin
                w_reset_req = w_viol;
                if (w_viol) begin
                    w_state_next    = StKill;
                    w_kill_cnt_next = 8'd0;
                end
            end
            StKill: begin
                w_exit      = (r_kill_cnt == KILL_MAX) && (io_bus.pc == RESET_HANDLER) && !w_viol;
                w_reset_req = !w_exit;
                if (w_exit) begin
                    w_state_next = StRun;
                end else if (r_kill_cnt != KILL_MAX) begin
                    w_kill_cnt_next = r_kill_cnt + 8'd1;
                end
            end
            default: w_state_next = StRun;
        endcase
    end

    always_ff @(posedge i_mclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StRun;
            r_kill_cnt    <= 8'd0;
            r_prev_in_tcb <= 1'b0;
            r_prev_pc     <= RESET_HANDLER;
            r_viol_code   <= 3'd0;
            r_viol_region <= 3'd0;
            r_viol_cnt    <= 8'd0;
        end else begin
            r_state       <= w_state_next;
            r_kill_cnt    <= w_kill_cnt_next;
            r_prev_in_tcb <= w_in_tcb;
            r_prev_pc     <= io_bus.pc;
            // KILL-time violations are logged but never recounted.
            if (w_reset_req && w_viol) begin
                r_viol_code   <= w_code;
                r_viol_region <= w_region;
            end
            if ((r_state == StRun) && w_viol && (r_viol_cnt != 8'hFF)) begin
                r_viol_cnt <= r_viol_cnt + 8'd1;
            end
        end
    end

    // Reset request must stay combinational so the offending access never retires.
    assign io_bus.reset       = i_reset_n & w_reset_req;
    assign io_bus.viol_code   = r_viol_code;
    assign io_bus.viol_region = r_viol_region;
    assign io_bus.viol_cnt    = r_viol_cnt;
endmodule

// File: tb/tb_x_stack_mpu.sv
// Self-checking bench for x_stack_mpu: directed vector table, a reset-mid-KILL sequence,
// then randomized cycles compared against a behavioural model of the protection rules.
module tb_x_stack_mpu;
    localparam int TCB_BASE = 'hA000;
    localparam int TCB_SIZE = 'h1000;
    localparam int TCB_LAST = TCB_BASE + TCB_SIZE - 2;
    localparam int RST_HND  = 0;
    localparam int KILL_MIN = 4;

    int rb[4] = '{'h0400, 'h6A00, 'h0230, 'h0270};
    int rs[4] = '{'h0100, 'h0040, 'h0020, 'h0002};
    int rp[4] = '{5, 1, 4, 6};

    logic mclk = 1'b0;
    logic reset_n = 1'b0;
    always #5 mclk = ~mclk;

    x_stack_mpu_if bus ();

    x_stack_mpu #(
        .NREG          (4),
        .REG_BASE      ({16'h0270, 16'h0230, 16'h6A00, 16'h0400}),
        .REG_SIZE      ({16'h0002, 16'h0020, 16'h0040, 16'h0100}),
        .REG_POLICY    ({3'b110, 3'b100, 3'b001, 3'b101}),
        .TCB_BASE      (16'hA000),
        .TCB_SIZE      (16'h1000),
        .RESET_HANDLER (16'h0000),
        .KILL_MIN      (KILL_MIN)
    ) dut (
        .i_mclk    (mclk),
        .i_reset_n (reset_n),
        .io_bus    (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model state.
    bit m_kill;
    int m_kc, m_prev_pc, m_code, m_region, m_cnt;
    bit m_prev_in;

    function automatic bit tcb_hit(input int pc);
        return (pc >= TCB_BASE) && (pc <= TCB_LAST);
    endfunction

    function automatic void model_reset();
        m_kill = 0; m_kc = 0; m_prev_in = 0; m_prev_pc = RST_HND;
        m_code = 0; m_region = 0; m_cnt = 0;
    endfunction

    function automatic void model_cause(input int pc, input int addr, input bit en, input bit wr,
                                        input bit irq, output int code, output int region);
        bit trusted;
        bit wr_ok;
        bit hit;
        trusted = tcb_hit(pc);
        wr_ok = 0;
        code = 0;
        region = 0;
        for (int i = 0; i < 4; i++) begin
            hit = (rs[i] != 0) && (addr >= rb[i]) && (addr <= rb[i] + rs[i] - 1);
            if (hit && rp[i][2]) wr_ok = 1;
            if (code == 0 && hit && !trusted && (en || wr) && rp[i][0]) begin
                code = 1; region = i;
            end
        end
        for (int i = 0; i < 4; i++) begin
            hit = (rs[i] != 0) && (addr >= rb[i]) && (addr <= rb[i] + rs[i] - 1);
            if (code == 0 && hit && !trusted && wr && rp[i][1]) begin
                code = 2; region = i;
            end
        end
        if (code == 0 && trusted && wr && !wr_ok) code = 3;
        else if (code == 0 && trusted && !m_prev_in && pc != TCB_BASE) code = 4;
        else if (code == 0 && !trusted && m_prev_in && m_prev_pc != TCB_LAST) code = 5;
        else if (code == 0 && irq && trusted) code = 6;
    endfunction

    function automatic void model_eval(input int pc, input int addr, input bit en, input bit wr,
                                       input bit irq, output int code, output int region,
                                       output bit exp_reset, output bit leave);
        model_cause(pc, addr, en, wr, irq, code, region);
        leave = m_kill && (m_kc == KILL_MIN) && (pc == RST_HND) && (code == 0);
        exp_reset = m_kill ? !leave : (code != 0);
    endfunction

    function automatic void model_commit(input int pc, input int addr, input bit en, input bit wr,
                                         input bit irq);
        int code, region;
        bit er, leave;
        model_eval(pc, addr, en, wr, irq, code, region, er, leave);
        if (er && code != 0) begin
            m_code = code; m_region = region;
        end
        if (!m_kill) begin
            if (code != 0) begin
                m_kill = 1; m_kc = 0;
                if (m_cnt < 255) m_cnt++;
            end
        end else if (leave) begin
            m_kill = 0;
        end else if (m_kc < KILL_MIN) begin
            m_kc++;
        end
        m_prev_in = tcb_hit(pc);
        m_prev_pc = pc;
    endfunction

    task automatic drive(input int pc, input int addr, input bit en, input bit wr, input bit irq);
        bus.pc = 16'(pc);
        bus.data_addr = 16'(addr);
        bus.data_en = en;
        bus.data_wr = wr;
        bus.irq = irq;
    endtask

    // Called about 1ns after a rising edge; leaves the clock low-phase untouched.
    task automatic do_rst(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, "_rst_out"}, 32'(bus.reset), 0);
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit rst;
        int pc, addr;
        bit en, wr, irq;
        int e_reset, e_code, e_region, e_cnt;
    } vec_t;
    vec_t vq[$];

    function automatic void add(input bit rst, input int pc, input int addr, input bit en,
                                input bit wr, input bit irq, input int er, input int ec,
                                input int erg, input int ecnt);
        vec_t v;
        v.rst = rst; v.pc = pc; v.addr = addr; v.en = en; v.wr = wr; v.irq = irq;
        v.e_reset = er; v.e_code = ec; v.e_region = erg; v.e_cnt = ecnt;
        vq.push_back(v);
    endfunction

    initial begin
        int code, region, pc, addr, r;
        bit er, leave, en, wr, irq;

        // Untrusted KMEM read, then a full kill window at the reset handler.
        add(1, 'h4400, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h4400, 'h6A00, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < KILL_MIN; i++) add(0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        // Trusted write to HMAC is legal, to 0x0200 is not.
        add(1, 'h4400, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'hA000, 'h0230, 1, 1, 0, 0, 0, 0, 0);
        add(0, 'hA002, 'h0200, 1, 1, 0, 1, 0, 0, 0);
        add(0, 'hA004, 0, 0, 0, 0, 1, 3, 0, 1);
        // Entry into the middle of the TCB vs entry at its base.
        add(1, 'h4400, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'hA002, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 'hA004, 0, 0, 0, 0, 1, 4, 0, 1);
        add(1, 'h4400, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'hA000, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'hA002, 0, 0, 0, 0, 0, 0, 0, 0);
        // Causes 3, 4 and 6 together: code 3 logged, one count.
        add(1, 'hA002, 'h0200, 1, 1, 1, 1, 0, 0, 0);
        add(0, 'hA004, 0, 0, 0, 0, 1, 3, 0, 1);
        // Causes 1 and 5 together: code 1 logged, one count.
        add(1, 'hA000, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h6000, 'h6A10, 1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        // Region edge, read-allowed CTR, write-protected CTR.
        add(1, 'h4400, 'h6A40, 1, 0, 0, 0, 0, 0, 0);
        add(0, 'h4400, 'h0270, 1, 0, 0, 0, 0, 0, 0);
        add(0, 'h4400, 'h0271, 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 2, 3, 1);
        // Legal exit from TCB_LAST, then SDATA read just past the TCB.
        add(1, 'hA000, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'hAFFE, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h4400, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'hB000, 'h0400, 1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);

        drive(0, 0, 0, 0, 0);
        model_reset();
        @(posedge mclk);
        #1;
        foreach (vq[k]) begin
            if (vq[k].rst) do_rst($sformatf("v%0d", k));
            drive(vq[k].pc, vq[k].addr, vq[k].en, vq[k].wr, vq[k].irq);
            @(negedge mclk);
            check($sformatf("v%0d_reset", k), 32'(bus.reset), vq[k].e_reset);
            check($sformatf("v%0d_code", k), 32'(bus.viol_code), vq[k].e_code);
            check($sformatf("v%0d_region", k), 32'(bus.viol_region), vq[k].e_region);
            check($sformatf("v%0d_cnt", k), 32'(bus.viol_cnt), vq[k].e_cnt);
            @(posedge mclk);
            model_commit(vq[k].pc, vq[k].addr, vq[k].en, vq[k].wr, vq[k].irq);
            #1;
        end

        // Core is now in KILL; an async reset must drop reset and clear the log at once.
        drive(0, 0, 0, 0, 0);
        check("midkill_before", 32'(bus.reset), 1);
        reset_n = 1'b0;
        #1;
        check("midkill_reset", 32'(bus.reset), 0);
        check("midkill_code", 32'(bus.viol_code), 0);
        check("midkill_region", 32'(bus.viol_region), 0);
        check("midkill_cnt", 32'(bus.viol_cnt), 0);
        model_reset();
        #1;
        reset_n = 1'b1;
        @(negedge mclk);
        check("after_rel_reset", 32'(bus.reset), 0);
        check("after_rel_cnt", 32'(bus.viol_cnt), 0);
        @(posedge mclk);
        model_commit(0, 0, 0, 0, 0);
        #1;

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) do_rst($sformatf("rnd%0d", c));
            case ($urandom_range(0, 9))
                0, 1:    pc = 0;
                2:       pc = TCB_BASE;
                3:       pc = TCB_BASE + 2 * $urandom_range(1, 8);
                4:       pc = TCB_LAST;
                5:       pc = TCB_LAST + 2;
                6:       pc = TCB_BASE - 2;
                7:       pc = 'h4400;
                default: pc = int'($urandom_range(0, 'hFFFF));
            endcase
            r = $urandom_range(0, 3);
            case ($urandom_range(0, 4))
                0:       addr = rb[r];
                1:       addr = rb[r] + rs[r] - 1;
                2:       addr = rb[r] + rs[r];
                3:       addr = rb[r] - 1;
                default: addr = int'($urandom_range(0, 'hFFFF));
            endcase
            en  = ($urandom_range(0, 2) == 0);
            wr  = ($urandom_range(0, 3) == 0);
            irq = ($urandom_range(0, 15) == 0);
            drive(pc, addr, en, wr, irq);
            @(negedge mclk);
            model_eval(pc, addr, en, wr, irq, code, region, er, leave);
            check($sformatf("rnd%0d_reset", c), 32'(bus.reset), 32'(er));
            check($sformatf("rnd%0d_code", c), 32'(bus.viol_code), m_code);
            check($sformatf("rnd%0d_region", c), 32'(bus.viol_region), m_region);
            check($sformatf("rnd%0d_cnt", c), 32'(bus.viol_cnt), m_cnt);
            @(posedge mclk);
            model_commit(pc, addr, en, wr, irq);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
